// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared sizing helpers for the elastic pipeline register chain.
//                cap_f(depth) returns how many entries the chain can hold.
//                cw_f(cap) returns the width of a counter that reaches cap.
//  Macro       : ELASTIC_PIPE_SKID_EN  (defined -> two entries per stage)
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

  // Capacity of a chain of 'depth' stages: main only, or main plus skid.
  function automatic int cap_f(input int depth);
`ifdef ELASTIC_PIPE_SKID_EN
    return 2 * depth;
`else
    return depth;
`endif
  endfunction

  // Counter width able to represent 0..cap inclusive.
  function automatic int cw_f(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/elastic_stage.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_stage
//  Description : One valid/ready register stage of the elastic chain.
//                Skid build: main + skid register, upstream ready registered.
//                Plain build: main register only, ready = !full || dn_ready.
//  Macro       : ELASTIC_PIPE_SKID_EN
//  Ports       : clk, rst         clock, synchronous active-high reset
//                i_flush          clear all valid bits on the next edge
//                i_up_valid/o_up_ready/i_up_data    upstream handshake
//                o_dn_valid/i_dn_ready/o_dn_data    downstream handshake
//  Revision    : 1.0  initial release
// ============================================================================
module elastic_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_up_valid,
  output logic             o_up_ready,
  input  logic [WIDTH-1:0] i_up_data,
  output logic             o_dn_valid,
  input  logic             i_dn_ready,
  output logic [WIDTH-1:0] o_dn_data
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q,  main_data_d;

`ifdef ELASTIC_PIPE_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;
  logic             w_accept;
  logic             w_main_free;

  // Ready depends only on a flop, so no path from i_dn_ready reaches upstream.
  assign o_up_ready  = !skid_valid_q;
  assign w_accept    = i_up_valid && !skid_valid_q;
  assign w_main_free = !main_valid_q || i_dn_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (w_main_free) begin
      // The older skid entry must move forward before any new input.
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = w_accept;
        if (w_accept) main_data_d = i_up_data;
      end
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = i_up_data;
    end
    if (i_flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  logic w_up_ready;

  // Combinational ready: a full stage can still accept if it drains this cycle.
  assign w_up_ready = !main_valid_q || i_dn_ready;
  assign o_up_ready = w_up_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    if (w_up_ready) begin
      main_valid_d = i_up_valid;
      if (i_up_valid) main_data_d = i_up_data;
    end
    if (i_flush) main_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
    end
  end
`endif

  assign o_dn_valid = main_valid_q;
  assign o_dn_data  = main_data_q;

endmodule
`default_nettype wire

// File: rtl/elastic_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_pipe
//  Description : DEPTH chained elastic stages with valid/ready handshake,
//                global flush and an occupancy counter.
//  Macro       : ELASTIC_PIPE_SKID_EN  (skid registers, fully registered ready)
//  Ports       : Clock, Reset     clock, synchronous active-high reset
//                Flush            squash all in-flight entries
//                InValid/InReady/InData     producer side
//                OutValid/OutReady/OutData  consumer side
//                Count            entries currently held (0..CAP)
//  Revision    : 1.0  initial release
// ============================================================================
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 1,
  localparam int CAP   = cap_f(DEPTH),
  localparam int CW    = cw_f(CAP)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] InData,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] OutData,
  output logic [CW-1:0]    Count
);

  // Element i is the link feeding stage i; element DEPTH is the consumer side.
  logic             vld_w [0:DEPTH];
  logic             rdy_w [0:DEPTH];
  logic [WIDTH-1:0] dat_w [0:DEPTH];

  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [CW-1:0] count_q, count_d;

  // Flush blocks both ends so no entry enters or leaves on a flush cycle.
  assign vld_w[0]     = InValid && !Flush;
  assign dat_w[0]     = InData;
  assign rdy_w[DEPTH] = OutReady && !Flush;

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      elastic_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk       (Clock),
        .rst       (Reset),
        .i_flush   (Flush),
        .i_up_valid(vld_w[i]),
        .o_up_ready(rdy_w[i]),
        .i_up_data (dat_w[i]),
        .o_dn_valid(vld_w[i+1]),
        .i_dn_ready(rdy_w[i+1]),
        .o_dn_data (dat_w[i+1])
      );
    end
  endgenerate

  assign InReady  = rdy_w[0] && !Flush;
  assign OutValid = vld_w[DEPTH] && !Flush;
  assign OutData  = dat_w[DEPTH];

  assign w_in_xfer  = InValid && InReady;
  assign w_out_xfer = OutValid && OutReady;

  always_comb begin
    count_d = count_q;
    case ({w_in_xfer, w_out_xfer})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (Flush) count_d = '0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign Count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elastic_pipe
//  Description : Randomised scoreboard bench for elastic_pipe. The reference
//                is an ordered queue of accepted payloads; ready/valid rules
//                and Count are derived from that queue's occupancy.
//  Macro       : ELASTIC_PIPE_SKID_EN (bench adapts to either build)
//  Revision    : 1.0  initial release
// ============================================================================
module tb_elastic_pipe;
  import pipe_pkg::*;

  localparam int WIDTH = 16;
  localparam int DEPTH = 3;
  localparam int CAP   = cap_f(DEPTH);
  localparam int CW    = cw_f(CAP);

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_data, out_data;
  logic [CW-1:0]    count;

  always #5 clk = ~clk;

  elastic_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clock   (clk),
    .Reset   (rst),
    .Flush   (flush),
    .InValid (in_valid),
    .InReady (in_ready),
    .InData  (in_data),
    .OutValid(out_valid),
    .OutReady(out_ready),
    .OutData (out_data),
    .Count   (count)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               acc_q[$];
  bit               started  = 1'b0;
  bit               lat_mode = 1'b0;
  int               total_in = 0, total_out = 0, dropped = 0, cnt_peak = 0;
  bit               prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (started) begin
      logic [WIDTH-1:0] e;
      int               a;
      chk("count", 64'(count), 64'(exp_q.size()));
      if (int'(count) > cnt_peak) cnt_peak = int'(count);
      if (flush) begin
        chk("flush_inready", 64'(in_ready), 64'd0);
        chk("flush_outvalid", 64'(out_valid), 64'd0);
      end
`ifdef ELASTIC_PIPE_SKID_EN
      if (exp_q.size() == CAP) chk("full_inready", 64'(in_ready), 64'd0);
`else
      chk("inready", 64'(in_ready), 64'(!flush && (exp_q.size() < CAP || out_ready)));
`endif
      if (exp_q.size() == 0) chk("empty_outvalid", 64'(out_valid), 64'd0);
      if (prev_stall && out_valid) chk("stall_stable", 64'(out_data), 64'(prev_data));
      prev_stall = out_valid && !out_ready && !rst;
      prev_data  = out_data;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("data", 64'(out_data), 64'(e));
        if (lat_mode) chk("latency", 64'(cyc - a), 64'(DEPTH));
        total_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        acc_q.push_back(cyc);
        total_in++;
      end
      if (rst || flush) begin
        dropped += exp_q.size();
        exp_q.delete();
        acc_q.delete();
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int  acc;
    bit  seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) step();
    chk("rst_outvalid", 64'(out_valid), 64'd0);
    chk("rst_outdata",  64'(out_data),  64'd0);
    chk("rst_inready",  64'(in_ready),  64'd1);
    chk("rst_count",    64'(count),     64'd0);
    rst = 1'b0;
    started = 1'b1;

    // Back-to-back 1,2,3 into an empty chain with a free consumer.
    lat_mode = 1'b1; out_ready = 1'b1; cnt_peak = 0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_data = WIDTH'(k);
      step();
    end
    in_valid = 1'b0;
    repeat (DEPTH + 3) step();
    lat_mode = 1'b0;
    chk("t1_peak", 64'(cnt_peak), 64'((DEPTH < 3) ? DEPTH : 3));
    chk("t1_outs", 64'(total_out), 64'd3);
    chk("t1_count", 64'(count), 64'd0);

    // Fill with a stalled consumer: exactly CAP accepts.
    out_ready = 1'b0; acc = 0;
    for (int i = 0; i < CAP + 4; i++) begin
      in_valid = 1'b1; in_data = WIDTH'($urandom);
      @(negedge clk);
      if (in_ready) acc++;
      step();
    end
    chk("full_accepts", 64'(acc), 64'(CAP));
    chk("full_count", 64'(count), 64'(CAP));
    chk("full_ready", 64'(in_ready), 64'd0);
`ifndef ELASTIC_PIPE_SKID_EN
    // Full chain, consumer and producer both active: simultaneous in/out.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = WIDTH'($urandom);
      @(negedge clk);
      chk("simul_count", 64'(count), 64'(CAP));
      chk("simul_out", 64'(out_valid), 64'd1);
      step();
    end
    out_ready = 1'b0;
`endif
    in_valid = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    repeat (CAP + DEPTH + 2) step();
    chk("drain_count", 64'(count), 64'd0);

    // Flush with two entries held.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(16'h10 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    flush = 1'b1; in_valid = 1'b1; in_data = WIDTH'(16'h55);
    @(negedge clk);
    chk("fl_count_before", 64'(count), 64'd2);
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_count_after", 64'(count), 64'd0);
    chk("fl_outvalid", 64'(out_valid), 64'd0);
    step();
    lat_mode = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_data = WIDTH'(16'hAA);
    step();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 * DEPTH + 4; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("aa_seen", 64'(seen), 64'd1);
    if (seen) chk("aa_data", 64'(out_data), 64'hAA);
    step();
    lat_mode = 1'b0;
    repeat (DEPTH + 2) step();

    // Reset while full and stalled.
    out_ready = 1'b0;
    for (int i = 0; i < CAP + 2; i++) begin
      in_valid = 1'b1; in_data = WIDTH'($urandom);
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("mrst_count",    64'(count),     64'd0);
    chk("mrst_outvalid", 64'(out_valid), 64'd0);
    chk("mrst_outdata",  64'(out_data),  64'd0);
    chk("mrst_inready",  64'(in_ready),  64'd1);
    rst = 1'b0;
    step();

    // Random traffic: toggling consumer first, then fully random with flushes.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = WIDTH'($urandom);
      out_ready = (i < 500) ? ((i % 2) == 0) : ($urandom_range(0, 2) != 0);
      flush     = (i >= 500) && ($urandom_range(0, 63) == 0);
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2 * CAP + DEPTH + 4) step();
    chk("end_model_empty", 64'(exp_q.size()), 64'd0);
    chk("end_count", 64'(count), 64'd0);
    chk("conservation", 64'(total_in), 64'(total_out + dropped));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
